// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding, ACK/NACK bus levels, default address.
// Used by i2c_bus_monitor (I2C_SLAVE_GLITCH_FILTER_EN majority helper) and i2c_slave.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX_BYTE,
      RX_ACK,
      TX_BYTE,
      TX_ACK,
      WAIT_STOP
   } i2c_state_t;

   localparam logic       ACK                = 1'b0;
   localparam logic       NACK               = 1'b1;
   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b0101000;
   localparam logic [3:0] BITS_PER_BYTE      = 4'd8;

   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronisers.
module i2c_bus_monitor
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_level,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_filt;
   logic       sda_filt;
   logic       scl_prev;
   logic       sda_prev;

   // Preset to 1 so an idle (pulled-up) bus produces no edges out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] scl_hist;
   logic [2:0] sda_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_hist <= 3'b111;
         sda_hist <= 3'b111;
      end else begin
         scl_hist <= {scl_hist[1:0], scl_sync[1]};
         sda_hist <= {sda_hist[1:0], sda_sync[1]};
      end
   end

   assign scl_filt = majority3(scl_hist);
   assign sda_filt = majority3(sda_hist);
`else
   assign scl_filt = scl_sync[1];
   assign sda_filt = sda_sync[1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_filt;
         sda_prev <= sda_filt;
      end
   end

   assign sda_level = sda_filt;
   assign scl_rise  = scl_filt & ~scl_prev;
   assign scl_fall  = ~scl_filt & scl_prev;
   assign start_det = scl_filt & scl_prev & sda_prev & ~sda_filt;
   assign stop_det  = scl_filt & scl_prev & ~sda_prev & sda_filt;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit-address I2C slave: receives bytes into ReadData, returns WriteData on reads.
// Optional I2C_SLAVE_GLITCH_FILTER_EN enables input majority filtering in i2c_bus_monitor.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
   input  logic       CLK_IN,
   input  logic       RST,
   input  logic       EN,
   input  logic       SCL,
   inout  wire        SDA,
   input  logic [7:0] WriteData,
   output logic [7:0] ReadData,
   output logic       RxValid,
   output logic       TxLoad,
   output logic       Read_WriteBar,
   output logic       Busy
);

   i2c_state_t state;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic       sda_low;

   logic sda_level;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_bus_monitor u_mon (
      .clk       (CLK_IN),
      .rst       (RST),
      .scl       (SCL),
      .sda       (SDA),
      .sda_level (sda_level),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // The drive register clears asynchronously, so reset releases the line at once.
   assign SDA = sda_low ? ACK : 1'bz;

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state         <= IDLE;
         bit_cnt       <= 4'd0;
         shift         <= 8'h00;
         sda_low       <= 1'b0;
         ReadData      <= 8'h00;
         RxValid       <= 1'b0;
         TxLoad        <= 1'b0;
         Read_WriteBar <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         RxValid <= 1'b0;
         TxLoad  <= 1'b0;
         if (!EN || stop_det) begin
            state   <= IDLE;
            sda_low <= 1'b0;
            Busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (start_det) begin
            state   <= ADDR;
            sda_low <= 1'b0;
            bit_cnt <= 4'd0;
         end else begin
            case (state)
               IDLE: ;
               ADDR: begin
                  if (scl_rise) begin
                     shift <= {shift[6:0], sda_level};
                     if (bit_cnt == BITS_PER_BYTE - 4'd1) begin
                        bit_cnt <= 4'd0;
                        // shift[6:0] already holds address bits 7..1; sda_level is R/W.
                        if (shift[6:0] == SLAVE_ADDR) begin
                           state         <= ADDR_ACK;
                           Read_WriteBar <= sda_level;
                           Busy          <= 1'b1;
                        end else begin
                           state <= WAIT_STOP;
                           Busy  <= 1'b0;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ADDR_ACK, RX_ACK: begin
                  // First fall starts the ACK pulse, second fall ends the 9th clock.
                  if (scl_fall) begin
                     if (!sda_low) begin
                        sda_low <= 1'b1;
                     end else if (state == ADDR_ACK && Read_WriteBar) begin
                        state   <= TX_BYTE;
                        shift   <= WriteData;
                        sda_low <= ~WriteData[7];
                        TxLoad  <= 1'b1;
                        bit_cnt <= 4'd0;
                     end else begin
                        state   <= RX_BYTE;
                        sda_low <= 1'b0;
                        bit_cnt <= 4'd0;
                     end
                  end
               end
               RX_BYTE: begin
                  if (scl_rise) begin
                     shift <= {shift[6:0], sda_level};
                     if (bit_cnt == BITS_PER_BYTE - 4'd1) begin
                        ReadData <= {shift[6:0], sda_level};
                        RxValid  <= 1'b1;
                        state    <= RX_ACK;
                        bit_cnt  <= 4'd0;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               TX_BYTE: begin
                  if (scl_rise && bit_cnt < BITS_PER_BYTE) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == BITS_PER_BYTE) begin
                        state   <= TX_ACK;
                        sda_low <= 1'b0;
                        bit_cnt <= 4'd0;
                     end else begin
                        shift   <= {shift[6:0], 1'b0};
                        sda_low <= ~shift[6];
                     end
                  end
               end
               TX_ACK: begin
                  if (scl_rise && sda_level == NACK) begin
                     state <= WAIT_STOP;
                  end else if (scl_fall) begin
                     state   <= TX_BYTE;
                     shift   <= WriteData;
                     sda_low <= ~WriteData[7];
                     TxLoad  <= 1'b1;
                     bit_cnt <= 4'd0;
                  end
               end
               WAIT_STOP: sda_low <= 1'b0;
               default:   state   <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bus-master bench for i2c_slave: writes, reads, foreign address, repeated START, EN, reset.
module tb_i2c_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       scl;
   logic       m_low;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rx_valid;
   logic       tx_load;
   logic       rw;
   logic       busy;
   wire        sda;

   int errors = 0;
   int checks = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;
   int dut_low = 0;

   int         r0, t0, d0;
   logic       ack;
   logic [7:0] d;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave dut (
      .CLK_IN        (clk),
      .RST           (rst),
      .EN            (en),
      .SCL           (scl),
      .SDA           (sda),
      .WriteData     (wdata),
      .ReadData      (rdata),
      .RxValid       (rx_valid),
      .TxLoad        (tx_load),
      .Read_WriteBar (rw),
      .Busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_valid) rx_cnt <= rx_cnt + 1;
      if (tx_load)  tx_cnt <= tx_cnt + 1;
   end

   // Cycles where the slave pulls SDA low while the master has released it.
   always @(negedge clk) begin
      if (!m_low && sda === 1'b0) dut_low <= dut_low + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      repeat (10) @(negedge clk);
   endtask

   task automatic start_cond();
      m_low = 1'b0; q();
      scl = 1'b1;   q();
      m_low = 1'b1; q();
      scl = 1'b0;   q();
   endtask

   task automatic stop_cond();
      m_low = 1'b1; q();
      scl = 1'b1;   q();
      m_low = 1'b0; q();
   endtask

   task automatic write_bit(input logic b);
      m_low = ~b; q();
      scl = 1'b1; q(); q();
      scl = 1'b0; q();
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b0; q();
      scl = 1'b1;   q();
      b = sda;      q();
      scl = 1'b0;   q();
   endtask

   task automatic write_byte(input logic [7:0] v, output logic a);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(b);
      a = (b === 1'b0);
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] v);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         v = {v[6:0], b};
      end
      write_bit(~master_ack);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; scl = 1'b1; m_low = 1'b0; wdata = 8'h00;
      repeat (5) @(negedge clk);
      chk("reset_rdata", rdata, 8'h00);
      chk("reset_rxvalid", rx_valid, 1'b0);
      chk("reset_txload", tx_load, 1'b0);
      chk("reset_rw", rw, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_sda", sda, 1'b1);
      rst = 1'b0; q();

      // Write 0x50 then 0xA5
      r0 = rx_cnt;
      start_cond();
      write_byte(8'h50, ack);
      chk("wr_addr_ack", ack, 1'b1);
      chk("wr_busy", busy, 1'b1);
      chk("wr_rw", rw, 1'b0);
      write_byte(8'hA5, ack);
      chk("wr_data_ack", ack, 1'b1);
      chk("wr_rdata", rdata, 8'hA5);
      chk("wr_rxvalid_cnt", rx_cnt - r0, 1);
      stop_cond(); q();
      chk("wr_busy_after_stop", busy, 1'b0);

      // Read 0x51: 0x3C with master ACK, 0xC3 with master NACK
      t0 = tx_cnt;
      wdata = 8'h3C;
      start_cond();
      write_byte(8'h51, ack);
      chk("rd_addr_ack", ack, 1'b1);
      chk("rd_rw", rw, 1'b1);
      wdata = 8'hC3;
      read_byte(1'b1, d);
      chk("rd_byte0", d, 8'h3C);
      read_byte(1'b0, d);
      chk("rd_byte1", d, 8'hC3);
      chk("rd_txload_cnt", tx_cnt - t0, 2);
      stop_cond(); q();
      chk("rd_busy_after_stop", busy, 1'b0);

      // Foreign address 0x29
      r0 = rx_cnt; d0 = dut_low;
      start_cond();
      write_byte(8'h52, ack);
      chk("na_ack", ack, 1'b0);
      chk("na_busy", busy, 1'b0);
      write_byte(8'h11, ack);
      stop_cond(); q();
      chk("na_sda_driven", dut_low - d0, 0);
      chk("na_rxvalid_cnt", rx_cnt - r0, 0);
      chk("na_busy_end", busy, 1'b0);

      // Partial write byte, repeated START, then read
      r0 = rx_cnt;
      start_cond();
      write_byte(8'h50, ack);
      chk("rs_wr_ack", ack, 1'b1);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      wdata = 8'h5A;
      start_cond();
      write_byte(8'h51, ack);
      chk("rs_rd_ack", ack, 1'b1);
      read_byte(1'b0, d);
      chk("rs_rd_byte", d, 8'h5A);
      stop_cond(); q();
      chk("rs_rxvalid_cnt", rx_cnt - r0, 0);
      chk("rs_rdata_kept", rdata, 8'hA5);

      // EN low: slave ignores the bus
      en = 1'b0;
      start_cond();
      write_byte(8'h50, ack);
      chk("en_low_ack", ack, 1'b0);
      chk("en_low_busy", busy, 1'b0);
      stop_cond();
      en = 1'b1; q();

      // Reset during the data ACK of 0xA5
      start_cond();
      write_byte(8'h50, ack);
      for (int i = 7; i >= 0; i--) write_bit(1'((8'hA5 >> i) & 8'h01));
      m_low = 1'b0; q();
      scl = 1'b1; q();
      chk("rst_ack_low", sda, 1'b0);
      rst = 1'b1; #1;
      chk("rst_sda_released", sda, 1'b1);
      @(negedge clk);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0; q();
      scl = 1'b0; q();
      stop_cond(); q();
      start_cond();
      write_byte(8'h50, ack);
      chk("post_rst_ack", ack, 1'b1);
      write_byte(8'h3C, ack);
      chk("post_rst_rdata", rdata, 8'h3C);
      stop_cond(); q();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      // 1-cycle SDA glitch with SCL high must not look like START
      @(negedge clk); m_low = 1'b1;
      @(negedge clk); m_low = 1'b0;
      q();
      scl = 1'b0; q();
      write_byte(8'h50, ack);
      chk("glitch_no_ack", ack, 1'b0);
      chk("glitch_busy", busy, 1'b0);
      stop_cond(); q();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b0101000, the 7-bit address this slave answers to.
REQ-002 SHALL have port CLK_IN, input, 1, system clock (at least 8x the SCL rate).
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port EN, input, 1; when low the block holds SDA released and ignores bus traffic.
REQ-005 SHALL have port SCL, input, 1, bus clock from the master.
REQ-006 SHALL have port SDA, inout, 1, open-drain data: the block drives only 1'b0, otherwise 1'bz.
REQ-007 SHALL have port WriteData, input, 8, byte returned to the master during a read, sampled at each byte load.
REQ-008 SHALL have port ReadData, output, 8, last byte received from the master.
REQ-009 SHALL have port RxValid, output, 1, one-CLK_IN pulse when ReadData updates.
REQ-010 SHALL have port TxLoad, output, 1, one-CLK_IN pulse when WriteData is captured.
REQ-011 SHALL have port Read_WriteBar, output, 1, the R/W bit of the current addressed transfer (1 = master reads).
REQ-012 SHALL have port Busy, output, 1, high from an address match until STOP or a non-matching address.

Function
REQ-013 SHALL pass SCL and SDA through 2-flop synchronizers and detect edges on the synchronized values only.
REQ-014 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high, in any state.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK and WAIT_STOP.
REQ-016 SHALL sample SDA on each synchronized SCL rising edge, MSB first; SDA drive changes only on a synchronized SCL falling edge.
REQ-017 ADDR: after 8 bits, if bits[7:1]==SLAVE_ADDR go to ADDR_ACK and latch bit0 into Read_WriteBar; otherwise go to WAIT_STOP with SDA released.
REQ-018 ADDR_ACK: drive SDA low for the 9th SCL period; on its falling edge go to RX_BYTE (write), or to TX_BYTE (read) with a WriteData capture and TxLoad pulse.
REQ-019 RX_BYTE: after 8 bits update ReadData, pulse RxValid once, then go to RX_ACK, drive ACK low for one SCL period, and return to RX_BYTE.
REQ-020 TX_BYTE: drive the MSB-first shift register (0 = drive low, 1 = release); after 8 bits release SDA and go to TX_ACK.
REQ-021 TX_ACK: master ACK (SDA low at SCL rise) reloads WriteData, pulses TxLoad and goes to TX_BYTE; NACK goes to WAIT_STOP.
REQ-022 Repeated START in any state SHALL go to ADDR with the bit counter cleared; STOP in any state SHALL go to IDLE, release SDA and clear Busy.
REQ-023 EN low SHALL force IDLE on the next CLK_IN edge; ReadData SHALL be preserved.
REQ-024 Bit counter SHALL be 4 bits and SHALL be cleared on START, on every ACK slot and on reset; it SHALL NOT wrap past 8 within a byte.

Reset
REQ-025 On RST: state=IDLE, SDA released (z), ReadData=8'h00, RxValid=0, TxLoad=0, Read_WriteBar=0, Busy=0, synchronizers preset to 1.
REQ-026 RST asserted mid-transfer SHALL release SDA immediately (asynchronously); after release the block SHALL wait for the next START.

Configuration
REQ-027 With I2C_SLAVE_GLITCH_FILTER_EN defined, synchronized SCL/SDA SHALL pass through a 3-sample majority filter, adding 2 CLK_IN latency and rejecting pulses of 1 CLK_IN or less.
REQ-028 Without I2C_SLAVE_GLITCH_FILTER_EN, the synchronizer outputs SHALL feed edge detection directly.

Structure
REQ-029 The FSM state encoding, the ACK/NACK constants and the default address SHALL live in the shared package i2c_pkg.
REQ-030 START/STOP/edge detection (including the optional filter) SHALL be the sub-module i2c_bus_monitor.

Verification
REQ-031 Write 0x50 (addr 0x28 + W), then 0xA5, then STOP -> ACK on both bytes, ReadData=0xA5, one RxValid pulse, Busy falls at STOP.
REQ-032 Read 0x51 with WriteData=0x3C, master ACK, then WriteData=0xC3, master NACK -> bytes 0x3C and 0xC3 on SDA, two TxLoad pulses, IDLE after STOP.
REQ-033 Address 0x52 (addr 0x29) -> SDA never driven, no RxValid, Busy stays 0.
REQ-034 Write 0x50, 4 data bits, repeated START, read 0x51 -> no RxValid for the partial byte, and the read proceeds correctly.
REQ-035 RST pulse during the ACK of 0xA5 -> SDA goes z within the reset assertion, ReadData=0x00, and the next START is recognised.
REQ-036 With the macro defined, a 1-CLK_IN SDA low glitch while SCL is high -> no START detected and no state change.
